// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fp_adder between NREQ requesters.
// Captures the winner's operands, waits ADD_LAT cycles, returns the tagged sum.
module fp_add_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADD_LAT = 1,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*3-1:0]    req_rmode,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic [2:0]           add_rmode,
  input  logic [31:0]          add_result,
  input  logic                 add_overflow,
  input  logic                 add_underflow,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_result,
  output logic                 resp_ov,
  output logic                 resp_ud,
  output logic                 busy
);

  // state | meaning
  // IDLE  | waiting for any req_valid; grants combinationally
  // BUSY  | operands held on the adder, counting down ADD_LAT cycles
  // RESP  | response presented until resp_ready
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  state_e         state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    op_a_q, op_b_q, res_q;
  logic [2:0]     op_rmode_q;
  logic           ov_q, ud_q;

  logic           grant_found;
  logic [IDW-1:0] grant_d;
  logic [31:0]    sel_a, sel_b;
  logic [2:0]     sel_rmode;

  // Two passes: requesters above last_grant first, then wrap to the low end.
  always_comb begin
    grant_found = 1'b0;
    grant_d     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_d     = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_d     = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_rmode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d == IDW'(i)) begin
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
        sel_rmode = req_rmode[3*i +: 3];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_found && (grant_d == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_rmode_q   <= '0;
      res_q        <= '0;
      ov_q         <= 1'b0;
      ud_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            op_a_q       <= sel_a;
            op_b_q       <= sel_b;
            op_rmode_q   <= sel_rmode;
            id_q         <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= CW'(ADD_LAT - 1);
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            res_q   <= add_result;
            ov_q    <= add_overflow;
            ud_q    <= add_underflow;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a       = op_a_q;
  assign add_b       = op_b_q;
  assign add_rmode   = op_rmode_q;
  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign resp_ov     = ov_q;
  assign resp_ud     = ud_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench: instance A (NREQ=2, ADD_LAT=1) and instance B (NREQ=3, ADD_LAT=3),
// both fed by a small table-driven adder model.
`timescale 1ns/1ps
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {ov, ud, result} for the handful of operand pairs the bench uses
  function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000, 64'h40000000_3F800000: fadd = {2'b00, 32'h40400000};
      64'h40000000_40000000:                        fadd = {2'b00, 32'h40800000};
      64'h7F7FFFFF_7F7FFFFF:                        fadd = {2'b10, 32'h7F800000};
      64'h00800001_80800000:                        fadd = {2'b01, 32'h00000001};
      default:                                      fadd = '0;
    endcase
  endfunction

  logic [1:0]  a_req_valid, a_req_ready;
  logic [63:0] a_req_a, a_req_b;
  logic [5:0]  a_req_rmode;
  logic [31:0] a_add_a, a_add_b, a_add_result, a_resp_result;
  logic [2:0]  a_add_rmode;
  logic        a_add_ov, a_add_ud, a_resp_valid, a_resp_ready, a_resp_ov, a_resp_ud, a_busy;
  logic [0:0]  a_resp_id;

  logic [2:0]  b_req_valid, b_req_ready;
  logic [95:0] b_req_a, b_req_b;
  logic [8:0]  b_req_rmode;
  logic [31:0] b_add_a, b_add_b, b_add_result, b_resp_result;
  logic [2:0]  b_add_rmode;
  logic        b_add_ov, b_add_ud, b_resp_valid, b_resp_ready, b_resp_ov, b_resp_ud, b_busy;
  logic [1:0]  b_resp_id;

  always_comb {a_add_ov, a_add_ud, a_add_result} = fadd(a_add_a, a_add_b);
  always_comb {b_add_ov, b_add_ud, b_add_result} = fadd(b_add_a, b_add_b);

  fp_add_arbiter #(.NREQ(2), .ADD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_a(a_req_a), .req_b(a_req_b), .req_rmode(a_req_rmode),
    .add_a(a_add_a), .add_b(a_add_b), .add_rmode(a_add_rmode),
    .add_result(a_add_result), .add_overflow(a_add_ov), .add_underflow(a_add_ud),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_id(a_resp_id),
    .resp_result(a_resp_result), .resp_ov(a_resp_ov), .resp_ud(a_resp_ud), .busy(a_busy));

  fp_add_arbiter #(.NREQ(3), .ADD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .req_rmode(b_req_rmode),
    .add_a(b_add_a), .add_b(b_add_b), .add_rmode(b_add_rmode),
    .add_result(b_add_result), .add_overflow(b_add_ov), .add_underflow(b_add_ud),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_id(b_resp_id),
    .resp_result(b_resp_result), .resp_ov(b_resp_ov), .resp_ud(b_resp_ud), .busy(b_busy));

  task automatic test_reset();
    rst = 1'b1;
    a_req_valid = '0; a_req_a = '0; a_req_b = '0; a_req_rmode = '0; a_resp_ready = 1'b0;
    b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_req_rmode = '0; b_resp_ready = 1'b0;
    #12;
    checks++; if (a_req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", a_resp_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    checks++; if ({a_add_a, a_resp_result, a_resp_id} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", a_add_a, a_resp_result, a_resp_id); end
    checks++; if ({b_busy, b_resp_valid, b_add_a} !== '0) begin errors++; $display("FAIL reset_b got %b/%b/%h exp 0", b_busy, b_resp_valid, b_add_a); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_op();
    @(posedge clk); #1;
    a_req_a[31:0] = 32'h3F800000; a_req_b[31:0] = 32'h40000000; a_req_rmode[2:0] = 3'd0;
    a_req_valid = 2'b01; a_resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", a_req_ready); end
    @(posedge clk); #1 a_req_valid = 2'b00;
    @(negedge clk);
    checks++; if ({a_busy, a_resp_valid, a_req_ready} !== 4'b1000) begin errors++; $display("FAIL single_busy got %b exp 1000", {a_busy, a_resp_valid, a_req_ready}); end
    checks++; if ({a_add_a, a_add_b} !== 64'h3F800000_40000000) begin errors++; $display("FAIL single_add_ops got %h exp 3f80000040000000", {a_add_a, a_add_b}); end
    @(negedge clk);
    checks++; if (a_resp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got resp_valid %b exp 1", a_resp_valid); end
    checks++; if ({a_resp_id, a_resp_result, a_resp_ov, a_resp_ud} !== {1'b0, 32'h40400000, 2'b00}) begin
      errors++; $display("FAIL single_resp got id %0d res %h ov %b ud %b exp 0 40400000 0 0", a_resp_id, a_resp_result, a_resp_ov, a_resp_ud); end
    @(negedge clk);
    checks++; if ({a_resp_valid, a_busy} !== 2'b00) begin errors++; $display("FAIL single_done got %b exp 00", {a_resp_valid, a_busy}); end
  endtask

  task automatic test_fairness();
    int exp_id = 1;
    int prev_cyc = 0;
    @(posedge clk); #1;
    a_req_a[63:32] = 32'h40000000; a_req_b[63:32] = 32'h40000000;
    a_req_valid = 2'b11; a_resp_ready = 1'b1;
    for (int op = 0; op < 6; op++) begin
      int n = 0;
      @(negedge clk);
      while (a_req_ready === 2'b00 && n < 10) begin @(negedge clk); n++; end
      checks++; if (a_req_ready !== (2'b01 << exp_id)) begin errors++; $display("FAIL fair_grant op %0d got %b exp id %0d", op, a_req_ready, exp_id); end
      if (op > 0) begin
        checks++; if (cyc - prev_cyc !== 3) begin errors++; $display("FAIL fair_throughput op %0d got %0d cycles exp 3", op, cyc - prev_cyc); end
      end
      prev_cyc = cyc;
      n = 0;
      @(negedge clk);
      while (a_resp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      checks++; if ({a_resp_valid, a_resp_id} !== {1'b1, exp_id[0]}) begin errors++; $display("FAIL fair_resp_id op %0d got v%b id %0d exp id %0d", op, a_resp_valid, a_resp_id, exp_id); end
      checks++; if (a_resp_result !== (exp_id == 1 ? 32'h40800000 : 32'h40400000)) begin errors++; $display("FAIL fair_result op %0d got %h", op, a_resp_result); end
      exp_id = 1 - exp_id;
    end
    a_req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n = 0;
    a_resp_ready = 1'b0;
    a_req_valid = 2'b11;
    @(negedge clk);
    while (a_resp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      checks++; if ({a_resp_valid, a_resp_id, a_resp_result, a_req_ready} !== {1'b1, 1'b1, 32'h40800000, 2'b00}) begin
        errors++; $display("FAIL bp_hold cyc %0d got v%b id %0d res %h rdy %b exp v1 id 1 40800000 00", k, a_resp_valid, a_resp_id, a_resp_result, a_req_ready); end
      @(negedge clk);
    end
    a_resp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({a_resp_valid, a_req_ready} !== 3'b001) begin errors++; $display("FAIL bp_release got v%b rdy %b exp v0 rdy 01", a_resp_valid, a_req_ready); end
    a_req_valid = 2'b00;
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy %b exp 0", a_busy); end
  endtask

  task automatic test_overflow();
    int n = 0;
    a_req_a[31:0] = 32'h7F7FFFFF; a_req_b[31:0] = 32'h7F7FFFFF; a_req_valid = 2'b01;
    @(negedge clk);
    while (a_resp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if ({a_resp_id, a_resp_result, a_resp_ov, a_resp_ud} !== {1'b0, 32'h7F800000, 2'b10}) begin
      errors++; $display("FAIL ovf_req0 got id %0d res %h ov %b ud %b exp 0 7f800000 1 0", a_resp_id, a_resp_result, a_resp_ov, a_resp_ud); end
    a_req_a[63:32] = 32'h7F7FFFFF; a_req_b[63:32] = 32'h7F7FFFFF; a_req_valid = 2'b10;
    n = 0;
    @(negedge clk);
    while (a_resp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if ({a_resp_id, a_resp_result, a_resp_ov, a_resp_ud} !== {1'b1, 32'h7F800000, 2'b10}) begin
      errors++; $display("FAIL ovf_req1 got id %0d res %h ov %b ud %b exp 1 7f800000 1 0", a_resp_id, a_resp_result, a_resp_ov, a_resp_ud); end
    a_req_a[31:0] = 32'h00800001; a_req_b[31:0] = 32'h80800000; a_req_valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (a_resp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if ({a_resp_id, a_resp_result, a_resp_ov, a_resp_ud} !== {1'b0, 32'h00000001, 2'b01}) begin
      errors++; $display("FAIL udf_req0 got id %0d res %h ov %b ud %b exp 0 00000001 0 1", a_resp_id, a_resp_result, a_resp_ov, a_resp_ud); end
    a_req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int n = 0;
    int highs = 0;
    int t0;
    @(posedge clk); #1;
    b_req_a[31:0] = 32'h3F800000; b_req_b[31:0] = 32'h40000000; b_req_valid = 3'b001; b_resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b001) begin errors++; $display("FAIL rstb_grant got %b exp 001", b_req_ready); end
    @(posedge clk); #1 b_req_valid = 3'b000;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++; if ({b_busy, b_resp_valid, b_req_ready, b_add_a} !== '0) begin
      errors++; $display("FAIL rstb_async got busy %b v %b rdy %b add_a %h exp all 0", b_busy, b_resp_valid, b_req_ready, b_add_a); end
    checks++; if (a_add_a !== 32'h0) begin errors++; $display("FAIL rsta_async got add_a %h exp 0", a_add_a); end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (b_resp_valid === 1'b1) highs++; end
    checks++; if (highs !== 0) begin errors++; $display("FAIL rstb_no_resp got %0d valid cycles exp 0", highs); end
    @(posedge clk); #1 b_req_valid = 3'b111;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b001) begin errors++; $display("FAIL rstb_regrant got %b exp 001", b_req_ready); end
    t0 = cyc;
    @(posedge clk); #1 b_req_valid = 3'b000;
    @(negedge clk);
    while (b_resp_valid !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    checks++; if (cyc - t0 !== 4) begin errors++; $display("FAIL rstb_latency got %0d cycles exp 4", cyc - t0); end
    checks++; if ({b_resp_id, b_resp_result} !== {2'd0, 32'h40400000}) begin errors++; $display("FAIL rstb_resp got id %0d res %h exp 0 40400000", b_resp_id, b_resp_result); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int n = 0;
    @(posedge clk); #1;
    b_req_a[95:64] = 32'h40000000; b_req_b[95:64] = 32'h40000000; b_req_valid = 3'b100;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b100) begin errors++; $display("FAIL wrap_grant2 got %b exp 100", b_req_ready); end
    @(posedge clk); #1 b_req_valid = 3'b001;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b000) begin errors++; $display("FAIL wrap_busy_ready got %b exp 000", b_req_ready); end
    while (b_resp_valid !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    checks++; if ({b_resp_id, b_resp_result} !== {2'd2, 32'h40800000}) begin errors++; $display("FAIL wrap_resp2 got id %0d res %h exp 2 40800000", b_resp_id, b_resp_result); end
    n = 0;
    @(negedge clk);
    while (b_req_ready === 3'b000 && n < 12) begin @(negedge clk); n++; end
    checks++; if (b_req_ready !== 3'b001) begin errors++; $display("FAIL wrap_grant0 got %b exp 001", b_req_ready); end
    @(posedge clk); #1 b_req_valid = 3'b000;
    n = 0;
    @(negedge clk);
    while (b_resp_valid !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    checks++; if ({b_resp_id, b_resp_result} !== {2'd0, 32'h40400000}) begin errors++; $display("FAIL wrap_resp0 got id %0d res %h exp 0 40400000", b_resp_id, b_resp_result); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_reset_busy();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
